uart_pkt_parser: RTL

UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_pkt_buf.sv | 25 ++
 rtl/uart_pkt_parser.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM encoding
// for the UART packet parser.
package uart_pkg;

  localparam logic [7:0] SOF = 8'hA5;
  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_LEN,
    S_GET_PAY,
    S_GET_CHK,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/uart_pkt_buf.sv
// uart_pkt_buf: payload register file,
// one synchronous write port, one async read port.
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: SOF/LEN/payload/CHK framer with
// inter-byte timeout and a valid/ready drain port.
module uart_pkt_parser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int MAX_LEN        = MAX_LEN_DEF,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / BAUD_RATE * 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        err_chk,
  output logic        err_len,
  output logic        err_timeout,
  output logic        overrun,
  output logic [15:0] pkt_count
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] rd_q, rd_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          ovr_q, ovr_d;

  logic       buf_we;
  logic [7:0] buf_rdata;
  logic       busy;
  logic       to_hit;
  logic       len_ok;
  logic       fire;
  logic       at_last;

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  assign busy = (state_q == S_GET_LEN)
             || (state_q == S_GET_PAY)
             || (state_q == S_GET_CHK);

  // a byte arriving on the expiry cycle wins
  assign to_hit = busy && !rx_done
               && (to_q == TO_LAST);

  assign len_ok = (rx_data != 8'd0)
               && (rx_data <= MAX_B);

  assign out_valid = (state_q == S_DRAIN);
  assign fire      = out_valid && out_ready;
  assign at_last   = (rd_q == len_q - LW'(1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    chk_d     = chk_q;
    cnt_d     = cnt_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    ovr_d     = 1'b0;
    buf_we    = 1'b0;
    to_d      = rx_done ? '0 : to_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        to_d = '0;
        if (rx_done && rx_data == SOF) begin
          state_d = S_GET_LEN;
        end
      end
      S_GET_LEN: begin
        if (rx_done) begin
          if (len_ok) begin
            len_d   = rx_data[LW-1:0];
            chk_d   = rx_data;
            idx_d   = '0;
            state_d = S_GET_PAY;
          end else begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_GET_PAY: begin
        if (rx_done) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_data;
          idx_d  = idx_q + LW'(1);
          if (idx_q == len_q - LW'(1)) begin
            state_d = S_GET_CHK;
          end
        end
      end
      S_GET_CHK: begin
        if (rx_done) begin
          if (rx_data == chk_q) begin
            rd_d    = '0;
            cnt_d   = cnt_q + 16'd1;
            state_d = S_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        to_d  = '0;
        ovr_d = rx_done;
        if (fire) begin
          if (at_last) begin
            rd_d    = '0;
            state_d = S_IDLE;
          end else begin
            rd_d = rd_q + LW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (to_hit) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      rd_q      <= '0;
      chk_q     <= '0;
      to_q      <= '0;
      cnt_q     <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
      chk_q     <= chk_d;
      to_q      <= to_d;
      cnt_q     <= cnt_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      ovr_q     <= ovr_d;
    end
  end

  // buffer is not reset, so mask it outside DRAIN
  assign out_data    = out_valid ? buf_rdata : 8'd0;
  assign out_last    = out_valid && at_last;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = to_hit;
  assign overrun     = ovr_q;
  assign pkt_count   = cnt_q;

endmodule
